// File: rtl/systolic_col_ctrl.sv
// Sequencer for one systolic column: streams B down the column with diagonal
// row skew, waits for the pipeline to flush, swaps result banks and drains one beat per row.
module systolic_col_ctrl #(
  parameter int unsigned data_size     = 8,
  parameter int unsigned systolic_size = 2,
  parameter int unsigned addr_width    = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [addr_width-1:0]          k_len,
  output logic                           busy,
  output logic                           done,
  output logic                           b_rd_en,
  output logic [addr_width-1:0]          b_addr,
  output logic [systolic_size-1:0]       a_rd_en,
  output logic [systolic_size-1:0]       cal_ele_cho,
  output logic                           mem_ele_cho,
  output logic                           mem_change,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic [$clog2(systolic_size):0] res_row
);

  localparam int unsigned S     = systolic_size;
  localparam int unsigned ROW_W = $clog2(systolic_size) + 1;

  // Degenerate parameterisations leave no legal column to sequence.
  if (data_size < 1 || systolic_size < 1) begin : g_param_guard
  end

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FEED  = 3'd1,
    FLUSH = 3'd2,
    SWAP  = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t                state, state_d;
  logic [addr_width-1:0] k_last, k_last_d;
  logic [ROW_W-1:0]      flush_cnt, flush_cnt_d;
  logic                  busy_d, done_d, b_rd_en_d, mem_ele_cho_d, mem_change_d, res_valid_d;
  logic [addr_width-1:0] b_addr_d;
  logic [S-1:0]          a_rd_en_d, cal_ele_cho_d;
  logic [ROW_W-1:0]      res_row_d;

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      k_last      <= '0;
      flush_cnt   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      b_rd_en     <= 1'b0;
      b_addr      <= '0;
      a_rd_en     <= '0;
      cal_ele_cho <= '0;
      mem_ele_cho <= 1'b0;
      mem_change  <= 1'b0;
      res_valid   <= 1'b0;
      res_row     <= '0;
    end else begin
      state       <= state_d;
      k_last      <= k_last_d;
      flush_cnt   <= flush_cnt_d;
      busy        <= busy_d;
      done        <= done_d;
      b_rd_en     <= b_rd_en_d;
      b_addr      <= b_addr_d;
      a_rd_en     <= a_rd_en_d;
      cal_ele_cho <= cal_ele_cho_d;
      mem_ele_cho <= mem_ele_cho_d;
      mem_change  <= mem_change_d;
      res_valid   <= res_valid_d;
      res_row     <= res_row_d;
    end
  end

  // Next state and next output values; b_addr doubles as the k counter during FEED.
  always_comb begin
    state_d       = state;
    k_last_d      = k_last;
    flush_cnt_d   = flush_cnt;
    done_d        = 1'b0;
    b_rd_en_d     = 1'b0;
    b_addr_d      = '0;
    mem_ele_cho_d = mem_ele_cho;
    mem_change_d  = 1'b0;
    res_valid_d   = 1'b0;
    res_row_d     = '0;

    case (state)
      IDLE: begin
        if (start) begin
          if (k_len != '0) begin
            state_d   = FEED;
            k_last_d  = k_len - addr_width'(1);
            b_rd_en_d = 1'b1;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      FEED: begin
        if (b_addr == k_last) begin
          state_d     = FLUSH;
          flush_cnt_d = '0;
        end else begin
          b_rd_en_d = 1'b1;
          b_addr_d  = b_addr + addr_width'(1);
        end
      end
      // S cycles: the last row's compute enable falls at the end of this window.
      FLUSH: begin
        if (flush_cnt == ROW_W'(S - 1)) begin
          state_d      = SWAP;
          mem_change_d = 1'b1;
        end else begin
          flush_cnt_d = flush_cnt + ROW_W'(1);
        end
      end
      SWAP: begin
        state_d       = DRAIN;
        mem_ele_cho_d = ~mem_ele_cho;
        res_valid_d   = 1'b1;
      end
      DRAIN: begin
        res_valid_d = 1'b1;
        res_row_d   = res_row;
        if (res_ready) begin
          if (res_row == ROW_W'(S - 1)) begin
            state_d     = DONE;
            done_d      = 1'b1;
            res_valid_d = 1'b0;
            res_row_d   = '0;
          end else begin
            res_row_d = res_row + ROW_W'(1);
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);

    // Diagonal skew: row i reads i cycles after B, computes one cycle after its read.
    a_rd_en_d    = '0;
    a_rd_en_d[0] = b_rd_en_d;
    for (int i = 1; i < int'(S); i++) begin
      a_rd_en_d[i] = a_rd_en[i-1];
    end
    cal_ele_cho_d = a_rd_en;
  end

endmodule

// File: tb/tb_systolic_col_ctrl.sv
// Bench for systolic_col_ctrl: two columns (S=2, S=4) on shared stimulus, checked
// every cycle against a timing model derived from the job start edge and accepted beats.
module tb_systolic_col_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] k_len;
  logic       res_ready;

  logic       busy2, done2, brd2, mec2, mch2, rv2;
  logic [7:0] ba2;
  logic [1:0] a2, c2, rr2;
  logic       busy4, done4, brd4, mec4, mch4, rv4;
  logic [7:0] ba4;
  logic [3:0] a4, c4;
  logic [2:0] rr4;

  always #5 clk = ~clk;

  systolic_col_ctrl #(.data_size(8), .systolic_size(2), .addr_width(8)) dut2 (
    .clk(clk), .reset(rst_n), .start(start), .k_len(k_len), .busy(busy2), .done(done2),
    .b_rd_en(brd2), .b_addr(ba2), .a_rd_en(a2), .cal_ele_cho(c2), .mem_ele_cho(mec2),
    .mem_change(mch2), .res_valid(rv2), .res_ready(res_ready), .res_row(rr2)
  );

  systolic_col_ctrl #(.data_size(8), .systolic_size(4), .addr_width(8)) dut4 (
    .clk(clk), .reset(rst_n), .start(start), .k_len(k_len), .busy(busy4), .done(done4),
    .b_rd_en(brd4), .b_addr(ba4), .a_rd_en(a4), .cal_ele_cho(c4), .mem_ele_cho(mec4),
    .mem_change(mch4), .res_valid(rv4), .res_ready(res_ready), .res_row(rr4)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Job model per column: start edge, K, beats accepted, cycle in which done is due.
  int sz [2] = '{2, 4};
  bit m_act  [2];
  bit m_fin  [2];
  bit m_bank [2];
  int m_t0   [2];
  int m_k    [2];
  int m_beats[2];
  int m_done [2];

  task automatic chk(input string tag, input int j, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s S=%0d cycle=%0d observed=%0h expected=%0h", tag, sz[j], cyc + 1, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < 2; j++) begin
      m_act[j] = 1'b0; m_fin[j] = 1'b0; m_bank[j] = 1'b0;
      m_t0[j] = 0; m_k[j] = 0; m_beats[j] = 0; m_done[j] = -1;
    end
  endtask

  // Advance the model over the edge that ends cycle e, using the inputs sampled there.
  task automatic model_edge(input int e);
    bit idle_before;
    int n, s, k;
    for (int j = 0; j < 2; j++) begin
      idle_before = !m_act[j];
      s = sz[j]; k = m_k[j]; n = e - m_t0[j];
      if (m_act[j]) begin
        if (e == m_done[j]) m_act[j] = 1'b0;
        else if (k > 0) begin
          if (n == k + s + 1) m_bank[j] = ~m_bank[j];
          if (n >= k + s + 2 && !m_fin[j] && res_ready) begin
            m_beats[j]++;
            if (m_beats[j] == s) begin
              m_fin[j]  = 1'b1;
              m_done[j] = e + 1;
            end
          end
        end
      end
      if (idle_before && start) begin
        m_act[j] = 1'b1; m_t0[j] = e; m_k[j] = int'(k_len);
        m_beats[j] = 0; m_fin[j] = 1'b0;
        m_done[j] = (k_len == 8'd0) ? e + 1 : -1;
      end
    end
  endtask

  // Compare every output of both columns with the model for cycle cyc+1.
  task automatic check_all();
    int c, n, s, k;
    logic [31:0] e_brd, e_ba, e_a, e_c, e_mch, e_rv, e_rr;
    logic [31:0] o_busy, o_done, o_brd, o_ba, o_a, o_c, o_mec, o_mch, o_rv, o_rr;
    c = cyc + 1;
    for (int j = 0; j < 2; j++) begin
      s = sz[j]; k = m_k[j]; n = c - m_t0[j];
      e_brd = 0; e_ba = 0; e_a = 0; e_c = 0; e_mch = 0; e_rv = 0; e_rr = 0;
      if (m_act[j] && k > 0) begin
        if (n >= 1 && n <= k) begin e_brd = 1; e_ba = 32'(n - 1); end
        for (int i = 0; i < s; i++) begin
          if (n >= 1 + i && n <= k + i) e_a[i] = 1'b1;
          if (n >= 2 + i && n <= 1 + k + i) e_c[i] = 1'b1;
        end
        if (n == k + s + 1) e_mch = 1;
        if (n >= k + s + 2 && !m_fin[j]) begin e_rv = 1; e_rr = 32'(m_beats[j]); end
      end
      if (j == 0) begin
        o_busy = 32'(busy2); o_done = 32'(done2); o_brd = 32'(brd2); o_ba = 32'(ba2);
        o_a = 32'(a2); o_c = 32'(c2); o_mec = 32'(mec2); o_mch = 32'(mch2);
        o_rv = 32'(rv2); o_rr = 32'(rr2);
      end else begin
        o_busy = 32'(busy4); o_done = 32'(done4); o_brd = 32'(brd4); o_ba = 32'(ba4);
        o_a = 32'(a4); o_c = 32'(c4); o_mec = 32'(mec4); o_mch = 32'(mch4);
        o_rv = 32'(rv4); o_rr = 32'(rr4);
      end
      chk("busy",        j, o_busy, 32'(m_act[j]));
      chk("done",        j, o_done, 32'(m_act[j] && c == m_done[j]));
      chk("b_rd_en",     j, o_brd,  e_brd);
      chk("b_addr",      j, o_ba,   e_ba);
      chk("a_rd_en",     j, o_a,    e_a);
      chk("cal_ele_cho", j, o_c,    e_c);
      chk("mem_ele_cho", j, o_mec,  32'(m_bank[j]));
      chk("mem_change",  j, o_mch,  e_mch);
      chk("res_valid",   j, o_rv,   e_rv);
      chk("res_row",     j, o_rr,   e_rr);
    end
  endtask

  task automatic tick(input logic st, input logic [7:0] k, input logic rdy);
    start = st; k_len = k; res_ready = rdy;
    @(posedge clk);
    cyc++;
    if (rst_n) model_edge(cyc);
    @(negedge clk);
    check_all();
  endtask

  // mode 0: ready high; 1: random ready plus ignored starts; 2: ready low for 3 drain cycles of S=2.
  task automatic run_until_idle(input int mode, input int max_cycles);
    int rel;
    logic rdy, st;
    for (int i = 0; i < max_cycles; i++) begin
      if (!m_act[0] && !m_act[1]) break;
      rdy = 1'b1; st = 1'b0;
      if (mode == 1) begin
        rdy = 1'($urandom_range(0, 1));
        st  = m_act[0] && m_act[1] && ($urandom_range(0, 3) == 0);
      end else if (mode == 2) begin
        rel = cyc + 1 - m_t0[0];
        rdy = !(rel >= m_k[0] + 4 && rel <= m_k[0] + 6);
      end
      tick(st, 8'($urandom_range(0, 255)), rdy);
    end
    chk("job_timeout", 0, 32'(m_act[0] | m_act[1]), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; k_len = 8'd0; res_ready = 1'b1;
    model_reset();
    #2;
    check_all();
    repeat (3) tick(1'b0, 8'd0, 1'b1);
    rst_n = 1'b1;
    repeat (2) tick(1'b0, 8'd0, 1'b1);

    // Basic job, then the same job with a stalled consumer.
    tick(1'b1, 8'd3, 1'b1); run_until_idle(0, 100);
    tick(1'b1, 8'd3, 1'b1); run_until_idle(2, 100);

    // K = 0 goes straight to done with no swap.
    tick(1'b1, 8'd0, 1'b1); run_until_idle(0, 10);
    tick(1'b0, 8'd0, 1'b1);

    // Start during FEED is dropped; the next job starts from IDLE.
    tick(1'b1, 8'd3, 1'b1);
    tick(1'b0, 8'd0, 1'b1);
    tick(1'b1, 8'd5, 1'b1);
    run_until_idle(0, 100);
    tick(1'b1, 8'd2, 1'b1); run_until_idle(0, 100);

    // Reset in the third FEED cycle aborts the job; a K=1 job follows.
    tick(1'b1, 8'd3, 1'b1);
    tick(1'b0, 8'd0, 1'b1);
    tick(1'b0, 8'd0, 1'b1);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    repeat (2) tick(1'b0, 8'd0, 1'b1);
    rst_n = 1'b1;
    tick(1'b1, 8'd1, 1'b1); run_until_idle(0, 100);

    // Largest K.
    tick(1'b1, 8'd255, 1'b1); run_until_idle(0, 600);

    // Random jobs with random back-pressure.
    repeat (25) begin
      tick(1'b1, 8'($urandom_range(0, 20)), 1'b1);
      run_until_idle(1, 400);
      tick(1'b0, 8'd0, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
